// File: rtl/ranger_patrol_ctrl.sv
// Ranger enemy patrol controller: position, direction and leg state for every ranger.
// A single step/clamp datapath serves all rangers, one per clock, once per frame.
module ranger_patrol_ctrl #(
    parameter int NUM_RANGERS = 5,
    parameter int STEP        = 5,
    parameter int LEG_STEPS   = 16,
    parameter int H_MIN       = 144,
    parameter int H_MAX       = 751,
    parameter int V_MIN       = 31,
    parameter int V_MAX       = 478
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        enable,
    input  logic        kill_valid,
    input  logic [2:0]  kill_idx,
    input  logic [2:0]  rd_sel,
    output logic [19:0] rd_position,
    output logic        rd_alive,
    output logic [3:0]  rd_dir,
    output logic        busy,
    output logic        update_done,
    output logic        tick_dropped
);

    localparam logic [9:0] H_LO     = 10'(H_MIN);
    localparam logic [9:0] H_HI     = 10'(H_MAX);
    localparam logic [9:0] V_LO     = 10'(V_MIN);
    localparam logic [9:0] V_HI     = 10'(V_MAX);
    localparam logic [9:0] STEP_W   = 10'(STEP);
    localparam logic [9:0] H_LO_LIM = 10'(H_MIN + STEP);
    localparam logic [9:0] H_HI_LIM = 10'(H_MAX - STEP);
    localparam logic [9:0] V_LO_LIM = 10'(V_MIN + STEP);
    localparam logic [9:0] V_HI_LIM = 10'(V_MAX - STEP);
    localparam logic [2:0] LAST_IDX = 3'(NUM_RANGERS - 1);
    localparam logic [3:0] NUM_W    = 4'(NUM_RANGERS);
    localparam logic [7:0] LEG_LAST = 8'(LEG_STEPS - 1);

    localparam logic [3:0] DIR_UP = 4'b1000;
    localparam logic [3:0] DIR_DN = 4'b0100;
    localparam logic [3:0] DIR_LF = 4'b0010;
    localparam logic [3:0] DIR_RT = 4'b0001;

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

    state_t     state;
    logic [2:0] idx;
    logic [9:0] hpos    [NUM_RANGERS];
    logic [9:0] vpos    [NUM_RANGERS];
    logic [3:0] dir     [NUM_RANGERS];
    logic [7:0] leg_cnt [NUM_RANGERS];
    logic       alive   [NUM_RANGERS];

    logic [9:0] cur_h, cur_v, nxt_h, nxt_v;
    logic [3:0] cur_dir, nxt_dir;
    logic [7:0] cur_leg, nxt_leg;
    logic       clamp;
    logic       kill_hit;

    function automatic logic [9:0] init_h(input int i);
        case (i)
            0: init_h = 10'd368;
            1: init_h = 10'd656;
            2: init_h = 10'd624;
            3: init_h = 10'd240;
            4: init_h = 10'd368;
            default: init_h = H_LO;
        endcase
    endfunction

    function automatic logic [9:0] init_v(input int i);
        case (i)
            0: init_v = 10'd127;
            1: init_v = 10'd127;
            2: init_v = 10'd329;
            3: init_v = 10'd447;
            4: init_v = 10'd240;
            default: init_v = V_LO;
        endcase
    endfunction

    function automatic logic [3:0] turn_cw(input logic [3:0] d);
        case (d)
            DIR_RT:  turn_cw = DIR_DN;
            DIR_DN:  turn_cw = DIR_LF;
            DIR_LF:  turn_cw = DIR_UP;
            DIR_UP:  turn_cw = DIR_RT;
            default: turn_cw = d;
        endcase
    endfunction

    // kill_valid is a single-cycle strobe with no back-pressure; it is always accepted.
    assign kill_hit = kill_valid && ({1'b0, kill_idx} < NUM_W);

    // Step/clamp datapath for the ranger currently addressed by idx.
    // Bounds are tested before the add/subtract so 10-bit arithmetic never wraps.
    always_comb begin
        cur_h   = hpos[idx];
        cur_v   = vpos[idx];
        cur_dir = dir[idx];
        cur_leg = leg_cnt[idx];
        nxt_h   = cur_h;
        nxt_v   = cur_v;
        nxt_dir = cur_dir;
        nxt_leg = cur_leg;
        clamp   = 1'b0;
        case (cur_dir)
            DIR_UP: if (cur_v < V_LO_LIM) begin
                nxt_v = V_LO; nxt_dir = DIR_DN; clamp = 1'b1;
            end else nxt_v = cur_v - STEP_W;
            DIR_DN: if (cur_v > V_HI_LIM) begin
                nxt_v = V_HI; nxt_dir = DIR_UP; clamp = 1'b1;
            end else nxt_v = cur_v + STEP_W;
            DIR_LF: if (cur_h < H_LO_LIM) begin
                nxt_h = H_LO; nxt_dir = DIR_RT; clamp = 1'b1;
            end else nxt_h = cur_h - STEP_W;
            DIR_RT: if (cur_h > H_HI_LIM) begin
                nxt_h = H_HI; nxt_dir = DIR_LF; clamp = 1'b1;
            end else nxt_h = cur_h + STEP_W;
            default: ;
        endcase
        if (clamp) begin
            nxt_leg = 8'd0;
        end else if (cur_leg == LEG_LAST) begin
            nxt_leg = 8'd0;
            nxt_dir = turn_cw(cur_dir);
        end else begin
            nxt_leg = cur_leg + 8'd1;
        end
    end

    always_comb begin
        rd_position = 20'd0;
        rd_alive    = 1'b0;
        rd_dir      = 4'b0000;
        if ({1'b0, rd_sel} < NUM_W) begin
            rd_position = {hpos[rd_sel], vpos[rd_sel]};
            rd_alive    = alive[rd_sel];
            rd_dir      = dir[rd_sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            idx          <= 3'd0;
            busy         <= 1'b0;
            update_done  <= 1'b0;
            tick_dropped <= 1'b0;
            for (int i = 0; i < NUM_RANGERS; i++) begin
                hpos[i]    <= init_h(i);
                vpos[i]    <= init_v(i);
                dir[i]     <= DIR_RT;
                leg_cnt[i] <= 8'd0;
                alive[i]   <= 1'b1;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_tick && enable) begin
                        state <= S_UPDATE;
                        idx   <= 3'd0;
                        busy  <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    // A kill aimed at the ranger being stepped wins and freezes it in place.
                    if (alive[idx] && !(kill_hit && kill_idx == idx)) begin
                        hpos[idx]    <= nxt_h;
                        vpos[idx]    <= nxt_v;
                        dir[idx]     <= nxt_dir;
                        leg_cnt[idx] <= nxt_leg;
                    end
                    if (idx == LAST_IDX) begin
                        state       <= S_DONE;
                        update_done <= 1'b1;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    update_done <= 1'b0;
                    busy        <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    update_done <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
            if (frame_tick && state != S_IDLE) tick_dropped <= 1'b1;
            if (kill_hit) alive[kill_idx] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ranger_patrol_ctrl.sv
// Directed bench for ranger_patrol_ctrl; a second instance with a narrow H_MAX exercises the right-edge clamp.
module tb_ranger_patrol_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        enable = 1'b1;
    logic        kill_valid = 1'b0;
    logic [2:0]  kill_idx = 3'd0;
    logic [2:0]  rd_sel = 3'd0;
    logic [19:0] rd_position;
    logic        rd_alive;
    logic [3:0]  rd_dir;
    logic        busy;
    logic        update_done;
    logic        tick_dropped;

    logic [19:0] rd_position2;
    logic        rd_alive2;
    logic [3:0]  rd_dir2;
    logic        busy2;
    logic        update_done2;
    logic        tick_dropped2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ranger_patrol_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
        .kill_valid(kill_valid), .kill_idx(kill_idx), .rd_sel(rd_sel),
        .rd_position(rd_position), .rd_alive(rd_alive), .rd_dir(rd_dir),
        .busy(busy), .update_done(update_done), .tick_dropped(tick_dropped)
    );

    ranger_patrol_ctrl #(.H_MAX(670)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
        .kill_valid(kill_valid), .kill_idx(kill_idx), .rd_sel(3'd1),
        .rd_position(rd_position2), .rd_alive(rd_alive2), .rd_dir(rd_dir2),
        .busy(busy2), .update_done(update_done2), .tick_dropped(tick_dropped2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_ranger(input logic [2:0] i, input logic [9:0] h, input logic [9:0] v,
                              input logic a, input logic [3:0] d);
        rd_sel = i;
        #1;
        check($sformatf("pos%0d", i), 32'(rd_position), 32'({h, v}));
        check($sformatf("alive%0d", i), 32'(rd_alive), 32'(a));
        check($sformatf("dir%0d", i), 32'(rd_dir), 32'(d));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Starts #1 after a rising edge; pulses frame_tick and waits (bounded) for the frame to finish.
    task automatic run_frame();
        int n;
        n = 0;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        while (busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("frame_end_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset values
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(update_done), 32'd0);
        check("rst_dropped", 32'(tick_dropped), 32'd0);
        do_reset();
        chk_ranger(3'd0, 10'd368, 10'd127, 1'b1, 4'b0001);
        chk_ranger(3'd1, 10'd656, 10'd127, 1'b1, 4'b0001);
        chk_ranger(3'd2, 10'd624, 10'd329, 1'b1, 4'b0001);
        chk_ranger(3'd3, 10'd240, 10'd447, 1'b1, 4'b0001);
        chk_ranger(3'd4, 10'd368, 10'd240, 1'b1, 4'b0001);
        chk_ranger(3'd7, 10'd0, 10'd0, 1'b0, 4'b0000);
        chk_ranger(3'd5, 10'd0, 10'd0, 1'b0, 4'b0000);

        // Single frame: busy T+1..T+6, update_done only at T+6
        @(posedge clk);
        #1;
        frame_tick = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            frame_tick = 1'b0;
            check($sformatf("busy_T+%0d", k), 32'(busy), 32'(k <= 6));
            check($sformatf("done_T+%0d", k), 32'(update_done), 32'(k == 6));
        end
        chk_ranger(3'd0, 10'd373, 10'd127, 1'b1, 4'b0001);
        chk_ranger(3'd1, 10'd661, 10'd127, 1'b1, 4'b0001);
        rd_sel = 3'd0;
        #1;
        check("narrow_f1", 32'(rd_position2), 32'({10'd661, 10'd127}));

        // Frames 2..17: leg turn on idx0, right-edge clamp on the narrow instance
        for (int f = 2; f <= 17; f++) begin
            @(posedge clk);
            #1;
            run_frame();
            if (f == 2) check("narrow_f2", 32'(rd_position2), 32'({10'd666, 10'd127}));
            if (f == 3) begin
                check("narrow_f3_pos", 32'(rd_position2), 32'({10'd670, 10'd127}));
                check("narrow_f3_dir", 32'(rd_dir2), 32'(4'b0010));
            end
            if (f == 4) check("narrow_f4", 32'(rd_position2), 32'({10'd665, 10'd127}));
            if (f == 16) begin
                chk_ranger(3'd0, 10'd448, 10'd127, 1'b1, 4'b0100);
                chk_ranger(3'd1, 10'd736, 10'd127, 1'b1, 4'b0100);
            end
            if (f == 17) chk_ranger(3'd0, 10'd448, 10'd132, 1'b1, 4'b0100);
        end
        check("no_drop_yet", 32'(tick_dropped), 32'd0);

        // Kill coinciding with idx2's update cycle (T+3)
        do_reset();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        kill_valid = 1'b1;
        kill_idx   = 3'd2;
        @(posedge clk); #1;
        kill_valid = 1'b0;
        while (busy) begin
            @(posedge clk); #1;
        end
        chk_ranger(3'd2, 10'd624, 10'd329, 1'b0, 4'b0001);
        chk_ranger(3'd3, 10'd245, 10'd447, 1'b1, 4'b0001);
        @(posedge clk); #1;
        run_frame();
        chk_ranger(3'd2, 10'd624, 10'd329, 1'b0, 4'b0001);
        chk_ranger(3'd0, 10'd378, 10'd127, 1'b1, 4'b0001);

        // Out-of-range kill index is ignored
        @(posedge clk); #1;
        kill_valid = 1'b1;
        kill_idx   = 3'd6;
        @(posedge clk); #1;
        kill_valid = 1'b0;
        chk_ranger(3'd4, 10'd378, 10'd240, 1'b1, 4'b0001);
        chk_ranger(3'd1, 10'd666, 10'd127, 1'b1, 4'b0001);

        // frame_tick during busy is dropped and the sticky flag holds
        @(posedge clk); #1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        check("drop_set", 32'(tick_dropped), 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
        end
        check("drop_no_frame", 32'(busy), 32'd0);
        check("drop_sticky", 32'(tick_dropped), 32'd1);
        chk_ranger(3'd0, 10'd383, 10'd127, 1'b1, 4'b0001);

        // Reset asserted mid-frame restores everything at once
        rd_sel = 3'd0;
        @(posedge clk); #1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(update_done), 32'd0);
        check("arst_dropped", 32'(tick_dropped), 32'd0);
        check("arst_pos0", 32'(rd_position), 32'({10'd368, 10'd127}));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
        end
        check("arst_no_resume", 32'(busy), 32'd0);
        chk_ranger(3'd1, 10'd656, 10'd127, 1'b1, 4'b0001);
        chk_ranger(3'd2, 10'd624, 10'd329, 1'b1, 4'b0001);

        // enable=0 in IDLE: tick ignored, no drop flag
        @(posedge clk); #1;
        enable     = 1'b0;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        check("dis_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("dis_dropped", 32'(tick_dropped), 32'd0);
        chk_ranger(3'd0, 10'd368, 10'd127, 1'b1, 4'b0001);
        enable = 1'b1;

        // Kill while IDLE
        @(posedge clk); #1;
        kill_valid = 1'b1;
        kill_idx   = 3'd4;
        @(posedge clk); #1;
        kill_valid = 1'b0;
        chk_ranger(3'd4, 10'd368, 10'd240, 1'b0, 4'b0001);
        @(posedge clk); #1;
        run_frame();
        chk_ranger(3'd4, 10'd368, 10'd240, 1'b0, 4'b0001);
        chk_ranger(3'd3, 10'd245, 10'd447, 1'b1, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
